// File: rtl/ifetch_packer_pkg.sv
// Shared constants, state encoding and RISC-V opcode helpers for the fetch packer.
// The backward-taken/forward-not-taken predictor is built only with STATIC_BTFN_PREDICT_EN.
package ifetch_packer_pkg;

    localparam int unsigned BUFFERSIZE = 10;
    localparam int unsigned ISSUEWIDTH = 4;

    localparam logic [7:0] CUT_FLUSH  = 8'hFF;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PACK,
        SEND,
        FLUSH
    } state_t;

    // JAL is always taken; a conditional branch is predicted taken only when it jumps backwards.
    function automatic logic btfn_taken(input logic [31:0] w);
        return (w[6:0] == OPC_JAL) || ((w[6:0] == OPC_BRANCH) && w[31]);
    endfunction

    function automatic logic [31:0] btfn_imm(input logic [31:0] w);
        if (w[6:0] == OPC_JAL) begin
            return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        end
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_packer_btfn_scan.sv
// Finds the first predicted-taken control transfer among the first n slots of a fetched line.
module btfn_scan #(
    parameter int unsigned BUFFERSIZE = ifetch_packer_pkg::BUFFERSIZE
) (
    input  logic [32*BUFFERSIZE-1:0] i_words,
    input  logic [32*BUFFERSIZE-1:0] i_pcs,
    input  logic [7:0]               i_n,
    output logic                     o_hit,
    output logic [7:0]               o_k,
    output logic [31:0]              o_target
);
    import ifetch_packer_pkg::*;

    always_comb begin
        o_hit    = 1'b0;
        o_k      = '0;
        o_target = '0;
        for (int unsigned i = 0; i < BUFFERSIZE; i++) begin
            if (!o_hit && (8'(i) < i_n) && btfn_taken(i_words[32*i +: 32])) begin
                o_hit    = 1'b1;
                o_k      = 8'(i);
                o_target = i_pcs[32*i +: 32] + btfn_imm(i_words[32*i +: 32]);
            end
        end
    end

endmodule

// File: rtl/ifetch_packer.sv
// Fetches a line, packs up to i_room instructions with their pcs, and hands packets over a toggle handshake.
// Define STATIC_BTFN_PREDICT_EN to cut packets at the first predicted-taken jump and redirect fetch there.
module ifetch_packer #(
    parameter int unsigned BUFFERSIZE = ifetch_packer_pkg::BUFFERSIZE,
    parameter int unsigned ISSUEWIDTH = ifetch_packer_pkg::ISSUEWIDTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirectPc,
    output logic                     o_memReq,
    output logic [31:0]              o_memAddr,
    input  logic                     i_memAck,
    input  logic [32*BUFFERSIZE-1:0] i_memData,
    output logic                     o_drive,
    input  logic                     i_free,
    output logic [64*BUFFERSIZE-1:0] o_alignedInstructionTable,
    output logic [7:0]               o_cutPostion_8,
    output logic                     o_gotJump,
    output logic [31:0]              o_jumpAddr,
    input  logic [7:0]               i_room
);
    import ifetch_packer_pkg::*;

    localparam logic [7:0]  SLOTS            = 8'(BUFFERSIZE);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam int unsigned unused_issuewidth = ISSUEWIDTH;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    drive_q, drive_d;
    logic [64*BUFFERSIZE-1:0] table_q, table_d;
    logic [7:0]              cut_q, cut_d;
    logic                    got_jump_q, got_jump_d;
    logic [31:0]             jump_addr_q, jump_addr_d;
    logic [32*BUFFERSIZE-1:0] data_q, data_d;
    logic                    pending_q, pending_d;
    logic [31:0]             flush_pc_q, flush_pc_d;

    logic [7:0]              n;
    logic [32*BUFFERSIZE-1:0] slot_pcs;
    logic [64*BUFFERSIZE-1:0] packed_table;
    logic                    enter_flush;
    logic                    scan_hit;
    logic [7:0]              scan_k;
    logic [31:0]             scan_target;
    logic                    pred_hit;
    logic [7:0]              pred_k;
    logic [31:0]             pred_target;

    always_comb begin
        n = (i_room > SLOTS) ? SLOTS : i_room;
        for (int unsigned i = 0; i < BUFFERSIZE; i++) begin
            slot_pcs[32*i +: 32]     = pc_q + 32'(4 * i);
            packed_table[64*i +: 64] = (8'(i) < n) ? {pc_q + 32'(4 * i), data_q[32*i +: 32]} : '0;
        end
    end

    btfn_scan #(
        .BUFFERSIZE(BUFFERSIZE)
    ) u_scan (
        .i_words (data_q),
        .i_pcs   (slot_pcs),
        .i_n     (n),
        .o_hit   (scan_hit),
        .o_k     (scan_k),
        .o_target(scan_target)
    );

`ifdef STATIC_BTFN_PREDICT_EN
    assign pred_hit    = scan_hit;
    assign pred_k      = scan_k;
    assign pred_target = scan_target;
`else
    logic unused_scan;
    assign unused_scan = ^{scan_hit, scan_k, scan_target};
    assign pred_hit    = 1'b0;
    assign pred_k      = '0;
    assign pred_target = '0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drive_d     = drive_q;
        table_d     = table_q;
        cut_d       = cut_q;
        got_jump_d  = got_jump_q;
        jump_addr_d = jump_addr_q;
        data_d      = data_q;
        pending_d   = pending_q;
        flush_pc_d  = i_redirect ? {i_redirectPc[31:2], 2'b00} : flush_pc_q;
        enter_flush = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_redirect) enter_flush = 1'b1;
                else            state_d     = FETCH;
            end
            FETCH: begin
                // The line in flight must still be acked before a redirect can take effect.
                if (i_memAck) begin
                    if (pending_q || i_redirect) begin
                        enter_flush = 1'b1;
                    end else begin
                        data_d  = i_memData;
                        state_d = PACK;
                    end
                end else if (i_redirect) begin
                    pending_d = 1'b1;
                end
            end
            PACK: begin
                if (i_redirect) begin
                    enter_flush = 1'b1;
                end else if (n != 8'd0) begin
                    table_d = packed_table;
                    drive_d = ~drive_q;
                    state_d = SEND;
                    if (pred_hit) begin
                        cut_d       = pred_k;
                        got_jump_d  = 1'b1;
                        jump_addr_d = pred_target;
                        pc_d        = {pred_target[31:2], 2'b00};
                    end else begin
                        cut_d       = n - 8'd1;
                        got_jump_d  = 1'b0;
                        jump_addr_d = '0;
                        pc_d        = pc_q + {22'b0, n, 2'b00};
                    end
                end
            end
            SEND: begin
                if (i_free == drive_q) begin
                    if (pending_q || i_redirect) enter_flush = 1'b1;
                    else                         state_d     = FETCH;
                end else if (i_redirect) begin
                    pending_d = 1'b1;
                end
            end
            FLUSH: begin
                if (i_free == drive_q) begin
                    pc_d      = flush_pc_d;
                    pending_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every route into FLUSH publishes the flush packet in the same cycle.
        if (enter_flush) begin
            state_d     = FLUSH;
            table_d     = '0;
            cut_d       = CUT_FLUSH;
            got_jump_d  = 1'b0;
            jump_addr_d = '0;
            drive_d     = ~drive_q;
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC_ALIGNED;
            drive_q     <= 1'b0;
            table_q     <= '0;
            cut_q       <= '0;
            got_jump_q  <= 1'b0;
            jump_addr_q <= '0;
            data_q      <= '0;
            pending_q   <= 1'b0;
            flush_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drive_q     <= drive_d;
            table_q     <= table_d;
            cut_q       <= cut_d;
            got_jump_q  <= got_jump_d;
            jump_addr_q <= jump_addr_d;
            data_q      <= data_d;
            pending_q   <= pending_d;
            flush_pc_q  <= flush_pc_d;
        end
    end

    assign o_memReq                  = (state_q == FETCH);
    assign o_memAddr                 = (state_q == FETCH) ? pc_q : '0;
    assign o_drive                   = drive_q;
    assign o_alignedInstructionTable = table_q;
    assign o_cutPostion_8            = cut_q;
    assign o_gotJump                 = got_jump_q;
    assign o_jumpAddr                = jump_addr_q;

endmodule
